// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, one-slave arbiter for the 16-bit machine memory bus. The CPU (m0)
// and a second requester (m1, e.g. DMA or boot loader) share the decoded slave
// bus. Transactions are serialised with round-robin priority. Each transaction
// produces a one-cycle slave strobe, and read data is routed back to the master
// that owns the transaction. A read that the slave never answers is
// force-completed after TIMEOUT cycles with zero data, and a sticky error flag
// is raised.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   mX_rd_en / mX_wr_en   level requests, held until the completion pulse
//   mX_addr               byte address, stable while the request is held
//   mX_wr_data/_wr_mask   write data and byte enables
//   mX_rd_data            read data, valid with mX_rd_valid, otherwise held
//   mX_rd_valid           one-cycle read completion pulse
//   mX_wr_done            one-cycle write completion pulse
//   s_addr, s_wr_data,
//   s_wr_mask             latched transaction fields to the slave decoder
//   s_rd_en / s_wr_en     one-cycle slave strobes
//   s_rd_data/s_rd_valid  slave read response
//   busy                  transaction in flight, including its completion cycle
//   timeout_err           sticky read-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255   // legal range 1..255 (8-bit wait counter)
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         m0_rd_en,
  input  logic         m0_wr_en,
  input  logic [15:0]  m0_addr,
  input  logic [W-1:0] m0_wr_data,
  input  logic [3:0]   m0_wr_mask,
  output logic [31:0]  m0_rd_data,
  output logic         m0_rd_valid,
  output logic         m0_wr_done,

  input  logic         m1_rd_en,
  input  logic         m1_wr_en,
  input  logic [15:0]  m1_addr,
  input  logic [W-1:0] m1_wr_data,
  input  logic [3:0]   m1_wr_mask,
  output logic [31:0]  m1_rd_data,
  output logic         m1_rd_valid,
  output logic         m1_wr_done,

  output logic [15:0]  s_addr,
  output logic         s_rd_en,
  output logic         s_wr_en,
  output logic [W-1:0] s_wr_data,
  output logic [3:0]   s_wr_mask,
  input  logic [31:0]  s_rd_data,
  input  logic         s_rd_valid,

  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Last counter value before the timeout fires: WAIT lasts TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q,       state_d;
  logic         rr_last_q,     rr_last_d;   // master granted most recently
  logic         owner_q,       owner_d;     // master owning the transaction
  logic         is_wr_q,       is_wr_d;
  logic [7:0]   cnt_q,         cnt_d;

  logic [15:0]  s_addr_q,      s_addr_d;
  logic [W-1:0] s_wr_data_q,   s_wr_data_d;
  logic [3:0]   s_wr_mask_q,   s_wr_mask_d;
  logic         s_rd_en_q,     s_rd_en_d;
  logic         s_wr_en_q,     s_wr_en_d;

  logic [31:0]  m0_rd_data_q,  m0_rd_data_d;
  logic [31:0]  m1_rd_data_q,  m1_rd_data_d;
  logic         m0_rd_valid_q, m0_rd_valid_d;
  logic         m1_rd_valid_q, m1_rd_valid_d;
  logic         m0_wr_done_q,  m0_wr_done_d;
  logic         m1_wr_done_q,  m1_wr_done_d;

  logic         busy_q,        busy_d;
  logic         timeout_err_q, timeout_err_d;

  logic         req0, req1, grant;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    owner_d       = owner_q;
    is_wr_d       = is_wr_q;
    cnt_d         = cnt_q;
    s_addr_d      = s_addr_q;
    s_wr_data_d   = s_wr_data_q;
    s_wr_mask_d   = s_wr_mask_q;
    s_rd_en_d     = 1'b0;
    s_wr_en_d     = 1'b0;
    m0_rd_data_d  = m0_rd_data_q;
    m1_rd_data_d  = m1_rd_data_q;
    m0_rd_valid_d = 1'b0;
    m1_rd_valid_d = 1'b0;
    m0_wr_done_d  = 1'b0;
    m1_wr_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    req0  = m0_rd_en | m0_wr_en;
    req1  = m1_rd_en | m1_wr_en;
    // On a tie the master that did not win last time gets the bus.
    grant = (req0 & req1) ? ~rr_last_q : req1;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d   = grant;
          rr_last_d = grant;
          if (grant) begin
            is_wr_d     = m1_wr_en;     // wr_en wins over a concurrent rd_en
            s_addr_d    = m1_addr;
            s_wr_data_d = m1_wr_data;
            s_wr_mask_d = m1_wr_mask;
          end else begin
            is_wr_d     = m0_wr_en;
            s_addr_d    = m0_addr;
            s_wr_data_d = m0_wr_data;
            s_wr_mask_d = m0_wr_mask;
          end
          s_wr_en_d = is_wr_d;
          s_rd_en_d = ~is_wr_d;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (is_wr_q) begin
          m0_wr_done_d = ~owner_q;
          m1_wr_done_d = owner_q;
          state_d      = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (s_rd_valid) begin
          if (owner_q) m1_rd_data_d = s_rd_data;
          else         m0_rd_data_d = s_rd_data;
          m0_rd_valid_d = ~owner_q;
          m1_rd_valid_d = owner_q;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Force-complete the read with zero data.
          if (owner_q) m1_rd_data_d = '0;
          else         m0_rd_data_d = '0;
          m0_rd_valid_d = ~owner_q;
          m1_rd_valid_d = owner_q;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // busy also covers the completion-pulse cycle, in which the FSM is
    // already back in IDLE and may be granting the next transaction.
    busy_d = (state_d != IDLE) | m0_rd_valid_d | m1_rd_valid_d |
             m0_wr_done_d | m1_wr_done_d;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_last_q     <= 1'b1;             // m0 wins the first tie
      owner_q       <= 1'b0;
      is_wr_q       <= 1'b0;
      cnt_q         <= '0;
      s_addr_q      <= '0;
      s_wr_data_q   <= '0;
      s_wr_mask_q   <= '0;
      s_rd_en_q     <= 1'b0;
      s_wr_en_q     <= 1'b0;
      m0_rd_data_q  <= '0;
      m1_rd_data_q  <= '0;
      m0_rd_valid_q <= 1'b0;
      m1_rd_valid_q <= 1'b0;
      m0_wr_done_q  <= 1'b0;
      m1_wr_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      owner_q       <= owner_d;
      is_wr_q       <= is_wr_d;
      cnt_q         <= cnt_d;
      s_addr_q      <= s_addr_d;
      s_wr_data_q   <= s_wr_data_d;
      s_wr_mask_q   <= s_wr_mask_d;
      s_rd_en_q     <= s_rd_en_d;
      s_wr_en_q     <= s_wr_en_d;
      m0_rd_data_q  <= m0_rd_data_d;
      m1_rd_data_q  <= m1_rd_data_d;
      m0_rd_valid_q <= m0_rd_valid_d;
      m1_rd_valid_q <= m1_rd_valid_d;
      m0_wr_done_q  <= m0_wr_done_d;
      m1_wr_done_q  <= m1_wr_done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_addr      = s_addr_q;
  assign s_wr_data   = s_wr_data_q;
  assign s_wr_mask   = s_wr_mask_q;
  assign s_rd_en     = s_rd_en_q;
  assign s_wr_en     = s_wr_en_q;
  assign m0_rd_data  = m0_rd_data_q;
  assign m1_rd_data  = m1_rd_data_q;
  assign m0_rd_valid = m0_rd_valid_q;
  assign m1_rd_valid = m1_rd_valid_q;
  assign m0_wr_done  = m0_wr_done_q;
  assign m1_wr_done  = m1_wr_done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. The stimulus process drives requests and the
// slave response, and pushes each expected bus event (slave strobe or master
// completion pulse, with the cycle it must appear in) into a scoreboard queue.
// A separate monitor samples on the falling edge, pops an entry for every
// event it sees and compares kind, cycle and payload. An event with no entry
// queued is reported as unexpected.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int W       = 32;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
  logic [15:0]  m0_addr, m1_addr;
  logic [W-1:0] m0_wr_data, m1_wr_data;
  logic [3:0]   m0_wr_mask, m1_wr_mask;
  logic [31:0]  m0_rd_data, m1_rd_data;
  logic         m0_rd_valid, m1_rd_valid, m0_wr_done, m1_wr_done;
  logic [15:0]  s_addr;
  logic         s_rd_en, s_wr_en;
  logic [W-1:0] s_wr_data;
  logic [3:0]   s_wr_mask;
  logic [31:0]  s_rd_data;
  logic         s_rd_valid;
  logic         busy, timeout_err;

  typedef enum {EV_S_WR, EV_S_RD, EV_M0_WD, EV_M1_WD, EV_M0_RV, EV_M1_RV} ev_t;
  typedef struct {
    ev_t         kind;
    int          cyc;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   c;

  bus_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_mask(m0_wr_mask), .m0_rd_data(m0_rd_data),
    .m0_rd_valid(m0_rd_valid), .m0_wr_done(m0_wr_done),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_mask(m1_wr_mask), .m1_rd_data(m1_rd_data),
    .m1_rd_valid(m1_rd_valid), .m1_wr_done(m1_wr_done),
    .s_addr(s_addr), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en),
    .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
    .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_exp(ev_t k, int at, logic [15:0] a, logic [31:0] d,
                          logic [3:0] m);
    exp_t e;
    e.kind = k; e.cyc = at; e.addr = a; e.data = d; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic observe(ev_t k, logic [15:0] a, logic [31:0] d, logic [3:0] m);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cycle %0d addr %h data %h", k.name(), cyc, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.addr !== a || e.data !== d ||
          e.mask !== m) begin
        errors++;
        $display("FAIL event: got %s cyc %0d addr %h data %h mask %h, want %s cyc %0d addr %h data %h mask %h",
                 k.name(), cyc, a, d, m, e.kind.name(), e.cyc, e.addr, e.data, e.mask);
      end
    end
  endtask

  // Monitor: samples every falling edge, away from the active clock edge.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (s_rd_en === 1'b1 && s_wr_en === 1'b1) begin
        errors++;
        $display("FAIL strobe_excl: s_rd_en=1 s_wr_en=1 want at most one (cycle %0d)", cyc);
      end
      if (s_wr_en === 1'b1)     observe(EV_S_WR, s_addr, s_wr_data, s_wr_mask);
      if (s_rd_en === 1'b1)     observe(EV_S_RD, s_addr, 32'h0, 4'h0);
      if (m0_wr_done === 1'b1)  observe(EV_M0_WD, 16'h0, 32'h0, 4'h0);
      if (m1_wr_done === 1'b1)  observe(EV_M1_WD, 16'h0, 32'h0, 4'h0);
      if (m0_rd_valid === 1'b1) observe(EV_M0_RV, 16'h0, m0_rd_data, 4'h0);
      if (m1_rd_valid === 1'b1) observe(EV_M1_RV, 16'h0, m1_rd_data, 4'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_rd_en = 0; m0_wr_en = 0; m0_addr = 0; m0_wr_data = 0; m0_wr_mask = 0;
    m1_rd_en = 0; m1_wr_en = 0; m1_addr = 0; m1_wr_data = 0; m1_wr_mask = 0;
    s_rd_data = 0; s_rd_valid = 0;
    tick(); tick();

    // Reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_s_addr", 32'(s_addr), 0);
    check("rst_s_wr_data", s_wr_data, 0);
    check("rst_m0_rd_data", m0_rd_data, 0);
    check("rst_m1_rd_data", m1_rd_data, 0);
    rst = 1'b0;
    tick();

    // m0 write, m1 idle: strobe in cycle 1, done in cycle 2, busy cycles 1-2
    c = cyc;
    m0_wr_en = 1; m0_addr = 16'h4000; m0_wr_data = 32'h0000_00A5; m0_wr_mask = 4'hF;
    push_exp(EV_S_WR, c + 1, 16'h4000, 32'h0000_00A5, 4'hF);
    push_exp(EV_M0_WD, c + 2, 16'h0, 32'h0, 4'h0);
    check("t1_busy_c0", 32'(busy), 0);
    tick(); check("t1_busy_c1", 32'(busy), 1);
    tick(); check("t1_busy_c2", 32'(busy), 1);
    m0_wr_en = 0;
    tick(); check("t1_busy_c3", 32'(busy), 0);

    // m1 read, slave answers the cycle after the strobe
    c = cyc;
    m1_rd_en = 1; m1_addr = 16'h8004;
    push_exp(EV_S_RD, c + 1, 16'h8004, 32'h0, 4'h0);
    push_exp(EV_M1_RV, c + 3, 16'h0, 32'hDEAD_BEEF, 4'h0);
    tick(); tick();
    s_rd_valid = 1; s_rd_data = 32'hDEAD_BEEF;
    tick();
    s_rd_valid = 0; s_rd_data = 0; m1_rd_en = 0;
    tick();
    check("t2_m1_rd_data_held", m1_rd_data, 32'hDEAD_BEEF);
    check("t2_m0_rd_data", m0_rd_data, 0);

    // m0 rd_en and wr_en together: treated as a write
    c = cyc;
    m0_rd_en = 1; m0_wr_en = 1; m0_addr = 16'h5000;
    m0_wr_data = 32'h5A5A_5A5A; m0_wr_mask = 4'h5;
    push_exp(EV_S_WR, c + 1, 16'h5000, 32'h5A5A_5A5A, 4'h5);
    push_exp(EV_M0_WD, c + 2, 16'h0, 32'h0, 4'h0);
    tick(); tick();
    m0_rd_en = 0; m0_wr_en = 0;
    tick();

    // m0 read, slave answers two cycles after the strobe
    c = cyc;
    m0_rd_en = 1; m0_addr = 16'h0010;
    push_exp(EV_S_RD, c + 1, 16'h0010, 32'h0, 4'h0);
    push_exp(EV_M0_RV, c + 4, 16'h0, 32'h1234_5678, 4'h0);
    tick(); tick(); tick();
    s_rd_valid = 1; s_rd_data = 32'h1234_5678;
    tick();
    s_rd_valid = 0; s_rd_data = 0; m0_rd_en = 0;
    tick();
    check("t4a_m0_rd_data", m0_rd_data, 32'h1234_5678);

    // m0 read to an unresponsive address: WAIT spans cycles c+2..c+256,
    // forced completion with zero data in cycle c+257
    c = cyc;
    m0_rd_en = 1; m0_addr = 16'h6000;
    push_exp(EV_S_RD, c + 1, 16'h6000, 32'h0, 4'h0);
    push_exp(EV_M0_RV, c + 257, 16'h0, 32'h0, 4'h0);
    repeat (256) tick();
    check("t4_err_before", 32'(timeout_err), 0);
    tick();
    m0_rd_en = 0;
    tick();
    check("t4_err_set", 32'(timeout_err), 1);
    check("t4_m0_rd_data_zero", m0_rd_data, 0);

    // Successful m1 write: timeout_err stays set
    c = cyc;
    m1_wr_en = 1; m1_addr = 16'h3000; m1_wr_data = 32'hCAFE_F00D; m1_wr_mask = 4'hC;
    push_exp(EV_S_WR, c + 1, 16'h3000, 32'hCAFE_F00D, 4'hC);
    push_exp(EV_M1_WD, c + 2, 16'h0, 32'h0, 4'h0);
    tick(); tick();
    m1_wr_en = 0;
    tick();
    check("t4_err_sticky", 32'(timeout_err), 1);

    // rst while m0 read is in WAIT, late s_rd_valid after release
    c = cyc;
    m0_rd_en = 1; m0_addr = 16'h9000;
    push_exp(EV_S_RD, c + 1, 16'h9000, 32'h0, 4'h0);
    tick(); tick();
    rst = 1;
    tick();
    check("t5_busy", 32'(busy), 0);
    check("t5_s_addr", 32'(s_addr), 0);
    check("t5_s_rd_en", 32'(s_rd_en), 0);
    check("t5_m1_rd_data", m1_rd_data, 0);
    check("t5_timeout_err", 32'(timeout_err), 0);
    rst = 0; s_rd_valid = 1; s_rd_data = 32'hFFFF_FFFF;
    push_exp(EV_S_RD, c + 4, 16'h9000, 32'h0, 4'h0);
    push_exp(EV_M0_RV, c + 6, 16'h0, 32'h0BAD_F00D, 4'h0);
    tick();
    s_rd_valid = 0; s_rd_data = 0;
    tick();
    s_rd_valid = 1; s_rd_data = 32'h0BAD_F00D;
    tick();
    s_rd_valid = 0; s_rd_data = 0; m0_rd_en = 0;
    tick();
    check("t5_m0_rd_data", m0_rd_data, 32'h0BAD_F00D);

    // Both masters write continuously after reset: m0, m1, m0, m1, m0, m1
    rst = 1;
    tick();
    rst = 0;
    c = cyc;
    m0_wr_en = 1; m0_addr = 16'h1000; m0_wr_data = 32'h1111_1111; m0_wr_mask = 4'hF;
    m1_wr_en = 1; m1_addr = 16'h2000; m1_wr_data = 32'h2222_2222; m1_wr_mask = 4'h3;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        push_exp(EV_S_WR, c + 1 + 2 * i, 16'h1000, 32'h1111_1111, 4'hF);
        push_exp(EV_M0_WD, c + 2 + 2 * i, 16'h0, 32'h0, 4'h0);
      end else begin
        push_exp(EV_S_WR, c + 1 + 2 * i, 16'h2000, 32'h2222_2222, 4'h3);
        push_exp(EV_M1_WD, c + 2 + 2 * i, 16'h0, 32'h0, 4'h0);
      end
    end
    repeat (12) tick();
    m0_wr_en = 0; m1_wr_en = 0;
    tick(); tick();
    check("t3_busy_end", 32'(busy), 0);

    tick();
    check("sb_drain", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 16-bit machine memory bus.
- Shares the decoded slave bus (BRAM, SPRAM, LED, UART address map) between the CPU (m0) and a second requester such as a DMA or boot loader (m1).
- Serialises transactions with round-robin priority, holds the slave request for exactly one cycle, and routes read data back to the owning master.
- Bounds reads to unmapped or unresponsive addresses with a timeout.

Parameters:
- W, 32, data width of write/read data.
- TIMEOUT, 255, max cycles in WAIT before a read is force-completed; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_rd_en  in  1  m0 read request; level, held until m0_rd_valid.
- m0_wr_en  in  1  m0 write request; level, held until m0_wr_done.
- m0_addr  in  16  m0 byte address; stable while request held.
- m0_wr_data  in  W  m0 write data.
- m0_wr_mask  in  4  m0 byte enables.
- m0_rd_data  out  32  read data to m0; valid with m0_rd_valid.
- m0_rd_valid  out  1  one-cycle read completion pulse to m0.
- m0_wr_done  out  1  one-cycle write completion pulse to m0.
- m1_rd_en, m1_wr_en, m1_addr, m1_wr_data, m1_wr_mask, m1_rd_data, m1_rd_valid, m1_wr_done: same widths and meaning as the m0 set, for m1.
- s_addr  out  16  address to the slave bus decoder.
- s_rd_en  out  1  slave read strobe; one cycle per transaction.
- s_wr_en  out  1  slave write strobe; one cycle per transaction.
- s_wr_data  out  W  slave write data.
- s_wr_mask  out  4  slave byte enables.
- s_rd_data  in  32  slave read data.
- s_rd_valid  in  1  slave read completion.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky; set on any read timeout.

Behaviour:
- All outputs registered. Reset values:
  - state = IDLE
  - all strobes, pulses, busy and timeout_err = 0
  - rd_data outputs, s_addr, s_wr_data, s_wr_mask = 0
  - rr_last = 1, so m0 wins the first tie.
- State IDLE:
  - Request from one master: that master is granted.
  - Requests from both masters: grant the master != rr_last.
  - On grant: latch addr, wr_data, wr_mask and op into s_* registers; set rr_last = granted master; go to ISSUE.
  - A master with rd_en and wr_en both high is treated as a write.
- State ISSUE (exactly one cycle):
  - s_rd_en or s_wr_en = 1 with latched s_addr/s_wr_data/s_wr_mask.
  - Write: next cycle pulse mX_wr_done = 1 and go to IDLE.
  - Read: go to WAIT, with the timeout counter cleared.
- State WAIT:
  - Strobes low; s_addr etc. held stable.
  - s_rd_valid high: capture s_rd_data into mX_rd_data; pulse mX_rd_valid the next cycle; go to IDLE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT: pulse mX_rd_valid with mX_rd_data = 0, set timeout_err, go to IDLE.
- Latency, no contention:
  - Write: request sampled in cycle 0, s_wr_en in cycle 1, wr_done in cycle 2.
  - Read: rd_valid one cycle after s_rd_valid; minimum 3 cycles for a slave answering the cycle after the strobe.
- Back-to-back: the earliest new grant is the cycle the done/valid pulse is driven. The master must drop its request in that same cycle, or it is re-granted.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- s_rd_valid outside WAIT is ignored and produces no completion pulse.
- The non-granted master sees no pulses; its rd_data holds its last value.
- rst mid-transaction: immediate return to IDLE, all outputs to reset values, no completion pulse. The pending request is re-arbitrated from scratch after reset releases.
- timeout_err clears only on rst.

Test Plan:
- m0 write, addr 0x4000, data 0x000000A5, mask 0xF, m1 idle -> s_wr_en is high exactly in cycle 1 with s_addr 0x4000; m0_wr_done pulses in cycle 2; busy high for cycles 1-2.
- m1 read, addr 0x8004; slave returns 0xDEADBEEF 1 cycle after s_rd_en -> m1_rd_valid one cycle later with m1_rd_data 0xDEADBEEF; m0 sees no pulse.
- m0 and m1 both request writes continuously for 6 transactions after reset -> grant order m0, m1, m0, m1, m0, m1; no cycle with s_rd_en and s_wr_en both high.
- m0 read, addr 0x6000, slave never asserts s_rd_valid -> after TIMEOUT cycles in WAIT, m0_rd_valid pulses with data 0; timeout_err = 1 and stays set through later successful transfers until rst.
- Assert rst while in WAIT, then release; a late s_rd_valid arrives -> no completion pulse on either master; all outputs equal reset values; the held request is re-granted 1 cycle after rst releases.
- m0 asserts rd_en and wr_en together -> a write is issued; s_rd_en stays 0; m0_wr_done pulses.
